// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS receive channel: symbol alignment from control tokens, decode, lock tracking.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT = 8,
  parameter int MAX_ACTIVE = 1023
) (
  input  logic       pixclk,
  input  logic       rst_n,
  input  logic [9:0] tmds_word,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       vde,
  output logic       locked,
  output logic [3:0] bit_offset,
  output logic [7:0] lock_loss_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int AW = $clog2(MAX_ACTIVE + 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(LOCK_COUNT - 1);
  localparam logic [AW-1:0] ACTIVE_LAST = AW'(MAX_ACTIVE - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [MW-1:0] match_cnt, match_cnt_nxt;
  logic [AW-1:0] active_cnt, active_cnt_nxt;
  logic [3:0]    offset_nxt;
  logic [7:0]    loss_nxt;

  logic [9:0]  raw_q, raw_qq;
  logic [19:0] win, win_sh;
  logic [9:0]  sym;
  logic        sym_tok;
  logic [1:0]  sym_ctrl;

  logic [9:0]  sym_q;
  logic        tok_q;
  logic [1:0]  ctrl_q;

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d    = '0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // The older word sits in the low half so bit 0 of win is earliest on the wire.
  always_comb begin
    win      = {raw_q, raw_qq};
    win_sh   = win >> bit_offset;
    sym      = win_sh[9:0];
    sym_tok  = 1'b1;
    sym_ctrl = 2'b00;
    case (sym)
      10'b1101010100: sym_ctrl = 2'b00;
      10'b0010101011: sym_ctrl = 2'b01;
      10'b0101010100: sym_ctrl = 2'b10;
      10'b1010101011: sym_ctrl = 2'b11;
      default:        sym_tok  = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    match_cnt_nxt  = match_cnt;
    active_cnt_nxt = active_cnt;
    offset_nxt     = bit_offset;
    loss_nxt       = lock_loss_count;
    case (state)
      SEARCH: begin
        if (sym_tok) begin
          if (match_cnt == MATCH_LAST) begin
            state_nxt      = LOCKED;
            match_cnt_nxt  = '0;
            active_cnt_nxt = '0;
          end else begin
            match_cnt_nxt = match_cnt + 1'b1;
          end
        end else begin
          match_cnt_nxt = '0;
          offset_nxt    = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
        end
      end
      LOCKED: begin
        if (sym_tok) begin
          active_cnt_nxt = '0;
        end else if (active_cnt == ACTIVE_LAST) begin
          state_nxt      = SEARCH;
          active_cnt_nxt = '0;
          match_cnt_nxt  = '0;
          if (lock_loss_count != 8'hFF)
            loss_nxt = lock_loss_count + 8'd1;
        end else begin
          active_cnt_nxt = active_cnt + 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= SEARCH;
      match_cnt       <= '0;
      active_cnt      <= '0;
      bit_offset      <= 4'd0;
      lock_loss_count <= 8'd0;
    end else begin
      state           <= state_nxt;
      match_cnt       <= match_cnt_nxt;
      active_cnt      <= active_cnt_nxt;
      bit_offset      <= offset_nxt;
      lock_loss_count <= loss_nxt;
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q  <= '0;
      raw_qq <= '0;
      sym_q  <= '0;
      tok_q  <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      raw_q  <= tmds_word;
      raw_qq <= raw_q;
      sym_q  <= sym;
      tok_q  <= sym_tok;
      ctrl_q <= sym_ctrl;
    end
  end

  // Output stage sees the state already updated for this symbol, so a lock loss blanks it.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      data <= 8'd0;
      ctrl <= 2'b00;
      vde  <= 1'b0;
    end else if (state == LOCKED) begin
      if (tok_q) begin
        data <= 8'd0;
        ctrl <= ctrl_q;
        vde  <= 1'b0;
      end else begin
        data <= decode(sym_q);
        vde  <= 1'b1;
      end
    end else begin
      data <= 8'd0;
      ctrl <= 2'b00;
      vde  <= 1'b0;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - directed bench for tmds_channel_decoder.
module tb_tmds_channel_decoder;

  logic       pixclk = 1'b0;
  logic       rst_n;
  logic [9:0] tmds_word;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       vde;
  logic       locked;
  logic [3:0] bit_offset;
  logic [7:0] lock_loss_count;

  tmds_channel_decoder dut (
    .pixclk          (pixclk),
    .rst_n           (rst_n),
    .tmds_word       (tmds_word),
    .data            (data),
    .ctrl            (ctrl),
    .vde             (vde),
    .locked          (locked),
    .bit_offset      (bit_offset),
    .lock_loss_count (lock_loss_count)
  );

  always #5 pixclk = ~pixclk;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] D00 = 10'h100;
  localparam logic [9:0] DFF = 10'h0FF;
  localparam logic [9:0] DA5 = 10'h163;
  localparam logic [9:0] D3C = 10'h241;

  int n_cmp = 0;
  int n_bad = 0;
  int ncall = 0;
  logic [9:0] prev = '0;

  logic       h_locked [8192];
  logic       h_vde    [8192];
  logic [7:0] h_data   [8192];
  logic [1:0] h_ctrl   [8192];

  // Stream is delayed by 3 bits: word = {current symbol low 7 bits, previous symbol high 3 bits}.
  task automatic send(input logic [9:0] s);
    tmds_word = {s[6:0], prev[9:7]};
    prev = s;
    @(posedge pixclk);
    #1;
    h_locked[ncall] = locked;
    h_vde[ncall]    = vde;
    h_data[ncall]   = data;
    h_ctrl[ncall]   = ctrl;
    ncall++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tmds_word = '0;
    repeat (3) @(posedge pixclk);
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0h expected 0", locked); end
    n_cmp++; if (vde !== 1'b0) begin n_bad++; $display("FAIL reset_vde: got %0h expected 0", vde); end
    n_cmp++; if ({data, ctrl} !== 10'd0) begin n_bad++; $display("FAIL reset_data_ctrl: got %0h expected 0", {data, ctrl}); end
    n_cmp++; if (bit_offset !== 4'd0) begin n_bad++; $display("FAIL reset_offset: got %0d expected 0", bit_offset); end
    n_cmp++; if (lock_loss_count !== 8'd0) begin n_bad++; $display("FAIL reset_loss: got %0d expected 0", lock_loss_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock;
    int waited;
    waited = 0;
    while (locked !== 1'b1 && waited < 18) begin
      send(T00);
      waited++;
    end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_acquire: got %0h expected 1 within 18 words", locked); end
    n_cmp++; if (bit_offset !== 4'd3) begin n_bad++; $display("FAIL lock_offset: got %0d expected 3", bit_offset); end
    repeat (3) send(T00);
    n_cmp++; if (ctrl !== 2'b00 || vde !== 1'b0) begin n_bad++; $display("FAIL lock_ctrl: got ctrl=%0h vde=%0h expected ctrl=0 vde=0", ctrl, vde); end
  endtask

  task automatic test_data;
    logic [9:0] syms [4];
    logic [7:0] exp  [4];
    int base;
    syms = '{D00, DFF, DA5, D3C};
    exp  = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    base = ncall;
    for (int i = 0; i < 4; i++) send(syms[i]);
    repeat (3) send(T00);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (h_vde[base+i+3] !== 1'b1 || h_data[base+i+3] !== exp[i]) begin
        n_bad++;
        $display("FAIL data_%0d: got vde=%0h data=%0h expected vde=1 data=%0h", i, h_vde[base+i+3], h_data[base+i+3], exp[i]);
      end
    end
    n_cmp++; if (h_vde[base+2] !== 1'b0) begin n_bad++; $display("FAIL data_latency: got vde=%0h expected 0 before 3rd edge", h_vde[base+2]); end
  endtask

  task automatic test_ctrl;
    int base;
    base = ncall;
    send(T01); send(DA5); send(T11);
    repeat (3) send(T00);
    n_cmp++; if (h_vde[base+3] !== 1'b0 || h_ctrl[base+3] !== 2'b01) begin n_bad++; $display("FAIL ctrl_01: got vde=%0h ctrl=%0h expected vde=0 ctrl=1", h_vde[base+3], h_ctrl[base+3]); end
    n_cmp++; if (h_vde[base+4] !== 1'b1 || h_ctrl[base+4] !== 2'b01 || h_data[base+4] !== 8'hA5) begin n_bad++; $display("FAIL ctrl_hold: got vde=%0h ctrl=%0h data=%0h expected 1 1 a5", h_vde[base+4], h_ctrl[base+4], h_data[base+4]); end
    n_cmp++; if (h_vde[base+5] !== 1'b0 || h_ctrl[base+5] !== 2'b11) begin n_bad++; $display("FAIL ctrl_11: got vde=%0h ctrl=%0h expected vde=0 ctrl=3", h_vde[base+5], h_ctrl[base+5]); end
  endtask

  task automatic test_lock_loss;
    int base;
    base = ncall;
    repeat (1023) send(D00);
    repeat (12) send(T00);
    n_cmp++; if (h_locked[base+1023] !== 1'b1) begin n_bad++; $display("FAIL loss_early: got locked=%0h expected 1 after 1022 data", h_locked[base+1023]); end
    n_cmp++; if (h_locked[base+1024] !== 1'b0) begin n_bad++; $display("FAIL loss_drop: got locked=%0h expected 0 after 1023 data", h_locked[base+1024]); end
    n_cmp++; if (h_vde[base+1024] !== 1'b1) begin n_bad++; $display("FAIL loss_vde_last_ok: got %0h expected 1", h_vde[base+1024]); end
    n_cmp++; if (h_vde[base+1025] !== 1'b0) begin n_bad++; $display("FAIL loss_vde_forced: got %0h expected 0", h_vde[base+1025]); end
    n_cmp++; if (h_locked[base+1031] !== 1'b0 || h_locked[base+1032] !== 1'b1) begin n_bad++; $display("FAIL relock_timing: got %0h%0h expected 01", h_locked[base+1031], h_locked[base+1032]); end
    n_cmp++; if (lock_loss_count !== 8'd1) begin n_bad++; $display("FAIL loss_count: got %0d expected 1", lock_loss_count); end
    n_cmp++; if (bit_offset !== 4'd3) begin n_bad++; $display("FAIL relock_offset: got %0d expected 3", bit_offset); end
  endtask

  task automatic test_back_to_back;
    int base;
    int drops;
    base = ncall;
    drops = 0;
    repeat (1022) send(DFF);
    send(T00);
    repeat (1022) send(DFF);
    repeat (3) send(T00);
    for (int i = base; i < ncall; i++) if (h_locked[i] !== 1'b1) drops++;
    n_cmp++; if (drops !== 0) begin n_bad++; $display("FAIL b2b_locked: got %0d unlocked words expected 0", drops); end
    n_cmp++; if (lock_loss_count !== 8'd1) begin n_bad++; $display("FAIL b2b_loss: got %0d expected 1", lock_loss_count); end
    n_cmp++; if (h_vde[base+2047] !== 1'b1 || h_data[base+2047] !== 8'hFF) begin n_bad++; $display("FAIL b2b_last_data: got vde=%0h data=%0h expected 1 ff", h_vde[base+2047], h_data[base+2047]); end
  endtask

  task automatic test_reset_mid;
    repeat (5) send(DA5);
    rst_n = 1'b0;
    #2;
    n_cmp++; if (locked !== 1'b0 || vde !== 1'b0) begin n_bad++; $display("FAIL midreset_lock_vde: got %0h%0h expected 00", locked, vde); end
    n_cmp++; if (data !== 8'd0) begin n_bad++; $display("FAIL midreset_data: got %0h expected 0", data); end
    n_cmp++; if (bit_offset !== 4'd0) begin n_bad++; $display("FAIL midreset_offset: got %0d expected 0", bit_offset); end
    n_cmp++; if (lock_loss_count !== 8'd0) begin n_bad++; $display("FAIL midreset_loss: got %0d expected 0", lock_loss_count); end
    @(posedge pixclk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    tmds_word = '0;
    test_reset;
    test_lock;
    test_data;
    test_ctrl;
    test_lock_loss;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
